// File: rtl/pulse_meas_pkg.sv
// Shared types and defaults for the pulse-width measurement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_meas_pkg;

  localparam int LEN_W = 10;

  localparam logic [31:0] DEF_MIN_CYCLES     = 32'd3;
  localparam logic [31:0] DEF_MAX_CYCLES     = 32'd50_000_000;  // 1 s at 50 MHz
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd50_000_000;  // 1 s at 50 MHz

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    RESULT
  } meas_state_t;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser for the raw pulse input, plus a one-cycle delayed copy.
// Latency: pulse_in to pulse_s 2 cycles, pulse_d one cycle later.
// Backpressure: none (free running).
// Ports: clk, reset (sync, active-high), pulse_in (async) -> pulse_s, pulse_d.
module pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic pulse_s,
  output logic pulse_d
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta    <= 1'b0;
      pulse_s <= 1'b0;
      pulse_d <= 1'b0;
    end else begin
      meta    <= pulse_in;
      pulse_s <= meta;
      pulse_d <= pulse_s;
    end
  end

endmodule

// File: rtl/pulse_meas_ctrl.sv
// Sequencer that arms one pulse-width measurement per start, gates the external
// length datapath for exactly the synchronised pulse-high cycles, and returns the result.
// Latency: start to meas_clear 1 cycle; falling edge of pulse_s to res_valid 1 cycle.
// Backpressure: result held in RESULT until res_valid & res_ready; start ignored while busy.
// Ports: clk, reset (sync, active-high), start, pulse_in; meas_clear/meas_gate/meas_length
//        to/from the length datapath; busy; res_valid/res_ready handshake carrying
//        res_length, res_timeout, res_overflow.
module pulse_meas_ctrl
  import pulse_meas_pkg::*;
#(
  parameter logic [31:0] MIN_CYCLES     = DEF_MIN_CYCLES,
  parameter logic [31:0] MAX_CYCLES     = DEF_MAX_CYCLES,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pulse_in,
  output logic             meas_clear,
  output logic             meas_gate,
  input  logic [LEN_W-1:0] meas_length,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LEN_W-1:0] res_length,
  output logic             res_timeout,
  output logic             res_overflow
);

  meas_state_t state, state_nxt;

  logic [31:0] width_cnt;
  logic [31:0] wait_cnt;
  logic        pulse_s;
  logic        pulse_d;
  logic        fall;
  logic        wait_expired;
  logic        ovf_hit;

  // one-cycle strobes from the FSM to the datapath registers
  logic start_acc;
  logic wait_inc;
  logic take_len;
  logic take_timeout;
  logic take_ovf;

  pulse_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .pulse_s  (pulse_s),
    .pulse_d  (pulse_d)
  );

  // MEASURE is only ever entered or held with pulse_s high, so this marks the
  // first low cycle after the measured pulse.
  assign fall         = pulse_d & ~pulse_s;
  assign wait_expired = (wait_cnt == TIMEOUT_CYCLES - 32'd1);
  assign ovf_hit      = (state == MEASURE) && pulse_s && (width_cnt == MAX_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_acc    = 1'b0;
    wait_inc     = 1'b0;
    take_len     = 1'b0;
    take_timeout = 1'b0;
    take_ovf     = 1'b0;
    meas_gate    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (wait_expired) begin
          take_timeout = 1'b1;
          state_nxt    = RESULT;
        end else begin
          wait_inc = 1'b1;
          // refuse to start on a pulse that was already high when armed
          if (!pulse_s) state_nxt = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        // the rising cycle itself is counted so the gate spans all N high cycles
        meas_gate = pulse_s;
        if (pulse_s) begin
          wait_inc  = 1'b1;
          state_nxt = MEASURE;
        end else if (wait_expired) begin
          take_timeout = 1'b1;
          state_nxt    = RESULT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      MEASURE: begin
        meas_gate = pulse_s & ~ovf_hit;
        if (ovf_hit) begin
          take_ovf  = 1'b1;
          state_nxt = RESULT;
        end else if (fall) begin
          if (width_cnt < MIN_CYCLES) begin
            state_nxt = CLEAR;  // glitch: rearm, the wait budget keeps running
          end else begin
            take_len  = 1'b1;
            state_nxt = RESULT;
          end
        end
      end
      RESULT: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_cnt    <= '0;
      wait_cnt     <= '0;
      res_length   <= '0;
      res_timeout  <= 1'b0;
      res_overflow <= 1'b0;
    end else begin
      // wait budget restarts only on a fresh start, not on a glitch rearm
      if (start_acc) begin
        wait_cnt     <= '0;
        res_timeout  <= 1'b0;
        res_overflow <= 1'b0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 32'd1;
      end

      if (state == CLEAR)  width_cnt <= '0;
      else if (meas_gate)  width_cnt <= width_cnt + 32'd1;

      // datapath count is already final in the capture cycle
      if (take_len || take_ovf) res_length <= meas_length;
      if (take_ovf)             res_overflow <= 1'b1;
      if (take_timeout) begin
        res_length  <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

  assign meas_clear = reset | (state == CLEAR);
  assign busy       = (state != IDLE);
  assign res_valid  = (state == RESULT);

endmodule

// File: tb/tb_pulse_meas_ctrl.sv
module tb_pulse_meas_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pulse_in;
  logic       meas_clear;
  logic       meas_gate;
  logic [9:0] meas_length;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [9:0] res_length;
  logic       res_timeout;
  logic       res_overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int gate_cnt = 0;
  int clr_cnt  = 0;
  int g0, c0, n;

  always #10 clk = ~clk;

  pulse_meas_ctrl #(
    .MIN_CYCLES     (32'd3),
    .MAX_CYCLES     (32'd10000),
    .TIMEOUT_CYCLES (32'd500)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pulse_in     (pulse_in),
    .meas_clear   (meas_clear),
    .meas_gate    (meas_gate),
    .meas_length  (meas_length),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_length   (res_length),
    .res_timeout  (res_timeout),
    .res_overflow (res_overflow)
  );

  // Length datapath beside the controller: counts gated cycles, scales by
  // FACTOR/2^32 (FACTOR 1473174, so 2916 cycles -> 1).
  logic [31:0] dp_cnt;
  logic [63:0] dp_prod;
  always @(posedge clk) begin
    if (meas_clear)     dp_cnt <= 32'd0;
    else if (meas_gate) dp_cnt <= dp_cnt + 32'd1;
  end
  assign dp_prod     = {32'd0, dp_cnt} * 64'd1473174;
  assign meas_length = dp_prod[41:32];

  always @(negedge clk) begin
    if (meas_gate === 1'b1)  gate_cnt++;
    if (meas_clear === 1'b1) clr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (res_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_low"}, 32'(res_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse(input int cycles);
    pulse_in = 1'b1;
    repeat (cycles) tick();
    pulse_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pulse_in = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    // reset state
    check("rst_clear", 32'(meas_clear), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gate", 32'(meas_gate), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_len", 32'(res_length), 32'd0);
    check("rst_to", 32'(res_timeout), 32'd0);
    check("rst_ovf", 32'(res_overflow), 32'd0);
    reset = 1'b0;
    tick();
    check("rel_clear", 32'(meas_clear), 32'd0);

    // nominal, 2916 cycles -> length 1
    g0 = gate_cnt;
    do_start();
    check("nom_clear_on", 32'(meas_clear), 32'd1);
    check("nom_busy", 32'(busy), 32'd1);
    tick();
    check("nom_clear_off", 32'(meas_clear), 32'd0);
    repeat (4) tick();
    pulse(2916);
    wait_valid("nom_valid", 20);
    check("nom_gate", 32'(gate_cnt - g0), 32'd2916);
    check("nom_len", 32'(res_length), 32'd1);
    check("nom_to", 32'(res_timeout), 32'd0);
    check("nom_ovf", 32'(res_overflow), 32'd0);
    handshake("nom");

    // nominal, 2915 cycles -> length 0
    g0 = gate_cnt;
    do_start();
    repeat (5) tick();
    pulse(2915);
    wait_valid("nom2_valid", 20);
    check("nom2_gate", 32'(gate_cnt - g0), 32'd2915);
    check("nom2_len", 32'(res_length), 32'd0);
    handshake("nom2");

    // glitch then real pulse
    do_start();
    repeat (5) tick();
    g0 = gate_cnt; c0 = clr_cnt;
    pulse(2);
    repeat (10) tick();
    check("gl_clear_once", 32'(clr_cnt - c0), 32'd1);
    check("gl_no_result", 32'(res_valid), 32'd0);
    pulse(2916);
    wait_valid("gl_valid", 20);
    check("gl_clear_total", 32'(clr_cnt - c0), 32'd1);
    check("gl_gate", 32'(gate_cnt - g0), 32'd2918);
    check("gl_len", 32'(res_length), 32'd1);
    handshake("gl");

    // overflow
    do_start();
    repeat (5) tick();
    g0 = gate_cnt;
    pulse(12000);
    check("ovf_valid", 32'(res_valid), 32'd1);
    check("ovf_gate", 32'(gate_cnt - g0), 32'd10000);
    check("ovf_flag", 32'(res_overflow), 32'd1);
    check("ovf_to", 32'(res_timeout), 32'd0);
    check("ovf_len", 32'(res_length), 32'd3);
    repeat (3) tick();
    handshake("ovf");

    // timeout: res_valid 501 cycles after the start edge
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd501);
    check("to_flag", 32'(res_timeout), 32'd1);
    check("to_ovf", 32'(res_overflow), 32'd0);
    check("to_len", 32'(res_length), 32'd0);
    handshake("to");

    // backpressure: result held, start and pulses ignored
    do_start();
    repeat (5) tick();
    pulse(2916);
    wait_valid("bp_valid", 20);
    g0 = gate_cnt; c0 = clr_cnt;
    for (int i = 0; i < 20; i++) begin
      start    = (i == 2 || i == 12);
      pulse_in = (i >= 5 && i < 11);
      tick();
    end
    start = 1'b0; pulse_in = 1'b0;
    repeat (3) tick();
    check("bp_hold_valid", 32'(res_valid), 32'd1);
    check("bp_hold_len", 32'(res_length), 32'd1);
    check("bp_no_gate", 32'(gate_cnt - g0), 32'd0);
    check("bp_no_clear", 32'(clr_cnt - c0), 32'd0);
    res_ready = 1'b1;
    start     = 1'b1;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("bp_valid_low", 32'(res_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    tick();
    check("bp_start_ignored", 32'(busy), 32'd0);
    check("bp_no_clear2", 32'(meas_clear), 32'd0);

    // reset in the middle of MEASURE
    do_start();
    repeat (5) tick();
    pulse_in = 1'b1;
    repeat (3000) tick();
    check("rm_gate_on", 32'(meas_gate), 32'd1);
    check("rm_dp_len", 32'(meas_length), 32'd1);
    reset = 1'b1;
    #1;
    check("rm_clear_in_reset", 32'(meas_clear), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_gate", 32'(meas_gate), 32'd0);
    check("rm_valid", 32'(res_valid), 32'd0);
    check("rm_len", 32'(res_length), 32'd0);
    check("rm_to", 32'(res_timeout), 32'd0);
    check("rm_ovf", 32'(res_overflow), 32'd0);
    check("rm_clear", 32'(meas_clear), 32'd0);
    check("rm_dp_cleared", 32'(meas_length), 32'd0);
    pulse_in = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
